// File: rtl/fft8_pkg.sv
// fft8_pkg -- shared definitions for the fft8_stream FFT engine.
//   cplx_t      : complex sample {re, im} at the default data width
//   NUM_STAGES  : number of registered butterfly stages
//   NUM_PTS     : transform length
//   cos45()     : W8 twiddle magnitude, round(0.70711 * 2^frac)
//   bitrev3()   : 3-bit bit-reverse index, gives the DIT input pairing
package fft8_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int NUM_STAGES = 3;
  localparam int NUM_PTS    = 8;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  function automatic int cos45(input int frac);
    longint num;
    num = (longint'(1) << frac) * 64'sd70711 + 64'sd50000;
    return int'(num / 64'sd100000);
  endfunction

  function automatic int bitrev3(input int idx);
    logic [2:0] b;
    b = idx[2:0];
    return int'({b[0], b[1], b[2]});
  endfunction

endpackage

// File: rtl/fft_bfly2.sv
// fft_bfly2 -- one combinational complex radix-2 butterfly.
//   sum = a + b', dif = a - b', where b' = b, or b' = -j*b when rot_mj = 1.
//   The -j rotation is folded into the add/sub so it stays exact even for
//   the most negative input. Arithmetic is carried at DATA_W+2 bits, then
//   optionally halved (scale = 1, arithmetic >>>1) and reduced to DATA_W.
// Ports:
//   rot_mj        in  apply -j to b before the butterfly
//   scale         in  divide both results by 2
//   a_re..b_im    in  operands, DATA_W signed
//   sum_*, dif_*  out results, DATA_W signed
//   sat           out (FFT8_SAT_EN only) a result was clamped
// Build option: FFT8_SAT_EN selects saturation instead of wrap-around.
module fft_bfly2
  import fft8_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     rot_mj,
  input  logic                     scale,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [DATA_W-1:0] sum_re,
  output logic signed [DATA_W-1:0] sum_im,
  output logic signed [DATA_W-1:0] dif_re,
  output logic signed [DATA_W-1:0] dif_im
`ifdef FFT8_SAT_EN
  ,
  output logic                     sat
`endif
);

  localparam int SW = DATA_W + 2;

  logic signed [SW-1:0] ar, ai, br, bi;
  logic signed [SW-1:0] s_re, s_im, d_re, d_im;

  always_comb begin
    ar = SW'(a_re);
    ai = SW'(a_im);
    if (rot_mj) begin
      // -j * (re + j im) = im - j re
      br = SW'(b_im);
      bi = -SW'(b_re);
    end else begin
      br = SW'(b_re);
      bi = SW'(b_im);
    end
    s_re = ar + br;
    s_im = ai + bi;
    d_re = ar - br;
    d_im = ai - bi;
    if (scale) begin
      s_re = s_re >>> 1;
      s_im = s_im >>> 1;
      d_re = d_re >>> 1;
      d_im = d_im >>> 1;
    end
  end

`ifdef FFT8_SAT_EN
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [SW-1:0]     WMAX = SW'(DMAX);
  localparam logic signed [SW-1:0]     WMIN = SW'(DMIN);

  function automatic logic signed [DATA_W-1:0] fit(input logic signed [SW-1:0] v);
    if (v > WMAX) return DMAX;
    if (v < WMIN) return DMIN;
    return DATA_W'(v);
  endfunction

  function automatic logic ovf(input logic signed [SW-1:0] v);
    return (v > WMAX) || (v < WMIN);
  endfunction

  assign sat = ovf(s_re) | ovf(s_im) | ovf(d_re) | ovf(d_im);
`else
  function automatic logic signed [DATA_W-1:0] fit(input logic signed [SW-1:0] v);
    return DATA_W'(v);
  endfunction
`endif

  assign sum_re = fit(s_re);
  assign sum_im = fit(s_im);
  assign dif_re = fit(d_re);
  assign dif_im = fit(d_im);

endmodule

// File: rtl/fft8_stream.sv
// fft8_stream -- pipelined 8-point radix-2 DIT FFT, one frame per cycle.
//   Three registered stages: S1 holds the g terms, S2 the h terms, S3 the
//   final bins (the output registers). All stages advance together when
//   adv = !out_valid || out_ready; otherwise the whole pipe stalls.
// Ports:
//   clk, rst            clock (rising), asynchronous active-high reset
//   in_valid/in_ready   input frame handshake (in_ready = adv)
//   in_re, in_im        x[n] at bits [n*DATA_W +: DATA_W]
//   scale_en            per-frame: halve after every stage
//   out_valid/out_ready output spectrum handshake
//   out_re, out_im      X[k] at bits [k*DATA_W +: DATA_W], natural order
//   sat_flag            (FFT8_SAT_EN only) sticky: some result was clamped
// Build option: define FFT8_SAT_EN to saturate instead of wrapping.
module fft8_stream
  import fft8_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*DATA_W-1:0]   in_re,
  input  logic [8*DATA_W-1:0]   in_im,
  input  logic                  scale_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*DATA_W-1:0]   out_re,
  output logic [8*DATA_W-1:0]   out_im
`ifdef FFT8_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int SW = DATA_W + 2;             // twiddle pre-sum width
  localparam int PW = DATA_W + TW_FRAC + 4;   // full product width
  localparam logic signed [PW-1:0] C45 = PW'(cos45(TW_FRAC));

  // ---------------------------------------------------------------- control
  logic [NUM_STAGES-1:0] vld_reg;
  logic                  s1_scale_reg, s2_scale_reg;
  logic                  adv, accept;

  assign out_valid = vld_reg[NUM_STAGES-1];
  assign adv       = !out_valid || out_ready;
  // Held low during reset so a frame presented with rst is never accepted.
  assign in_ready  = adv && !rst;
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------- data
  logic signed [DATA_W-1:0] x_re [NUM_PTS];
  logic signed [DATA_W-1:0] x_im [NUM_PTS];
  logic signed [DATA_W-1:0] g_re_next [NUM_PTS], g_im_next [NUM_PTS];
  logic signed [DATA_W-1:0] h_re_next [NUM_PTS], h_im_next [NUM_PTS];
  logic signed [DATA_W-1:0] o_re_next [NUM_PTS], o_im_next [NUM_PTS];
  logic signed [DATA_W-1:0] g_re_reg  [NUM_PTS], g_im_reg  [NUM_PTS];
  logic signed [DATA_W-1:0] h_re_reg  [NUM_PTS], h_im_reg  [NUM_PTS];
  logic signed [DATA_W-1:0] o_re_reg  [NUM_PTS], o_im_reg  [NUM_PTS];
  logic signed [DATA_W-1:0] t_re [4], t_im [4];

  logic [3:0] s1_ovf, s2_ovf, s3_ovf, tw_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PTS; gi++) begin : g_io
      assign x_re[gi] = in_re[gi*DATA_W +: DATA_W];
      assign x_im[gi] = in_im[gi*DATA_W +: DATA_W];
      assign out_re[gi*DATA_W +: DATA_W] = o_re_reg[gi];
      assign out_im[gi*DATA_W +: DATA_W] = o_im_reg[gi];
    end

    // Stage 1: 2-point DFTs on bit-reversed pairs (0,4) (2,6) (1,5) (3,7).
    for (gi = 0; gi < 4; gi++) begin : g_s1
      localparam int IA = bitrev3(2*gi);
      localparam int IB = bitrev3(2*gi + 1);
      fft_bfly2 #(.DATA_W(DATA_W)) u_bfly (
        .rot_mj (1'b0),
        .scale  (scale_en),
        .a_re   (x_re[IA]),
        .a_im   (x_im[IA]),
        .b_re   (x_re[IB]),
        .b_im   (x_im[IB]),
        .sum_re (g_re_next[2*gi]),
        .sum_im (g_im_next[2*gi]),
        .dif_re (g_re_next[2*gi+1]),
        .dif_im (g_im_next[2*gi+1])
`ifdef FFT8_SAT_EN
        ,
        .sat    (s1_ovf[gi])
`endif
      );
    end

    // Stage 2: two 4-point combinations; the odd pair takes the -j twiddle.
    for (gi = 0; gi < 4; gi++) begin : g_s2
      localparam int IA = (gi / 2) * 4 + (gi % 2);
      fft_bfly2 #(.DATA_W(DATA_W)) u_bfly (
        .rot_mj (gi % 2 == 1),
        .scale  (s1_scale_reg),
        .a_re   (g_re_reg[IA]),
        .a_im   (g_im_reg[IA]),
        .b_re   (g_re_reg[IA+2]),
        .b_im   (g_im_reg[IA+2]),
        .sum_re (h_re_next[IA]),
        .sum_im (h_im_next[IA]),
        .dif_re (h_re_next[IA+2]),
        .dif_im (h_im_next[IA+2])
`ifdef FFT8_SAT_EN
        ,
        .sat    (s2_ovf[gi])
`endif
      );
    end

    // Stage 3 twiddles on the odd half: k=0 and k=2 are exact (1 and -j,
    // the latter folded into the butterfly); k=1 and k=3 use COS45.
    for (gi = 0; gi < 4; gi++) begin : g_tw
      if (gi == 1 || gi == 3) begin : g_mul
        logic signed [SW-1:0] u_re, u_im;
        logic signed [PW-1:0] p_re, p_im;
        always_comb begin
          if (gi == 1) begin
            // (a + jb) * (1 - j) : re = a + b, im = b - a
            u_re = SW'(h_re_reg[gi+4]) + SW'(h_im_reg[gi+4]);
            u_im = SW'(h_im_reg[gi+4]) - SW'(h_re_reg[gi+4]);
          end else begin
            // (a + jb) * (-1 - j) : re = b - a, im = -a - b
            u_re = SW'(h_im_reg[gi+4]) - SW'(h_re_reg[gi+4]);
            u_im = -SW'(h_re_reg[gi+4]) - SW'(h_im_reg[gi+4]);
          end
          // Floor rounding: arithmetic shift of the full-width product.
          p_re = (PW'(u_re) * C45) >>> TW_FRAC;
          p_im = (PW'(u_im) * C45) >>> TW_FRAC;
        end
        assign t_re[gi]   = fit_tw(p_re);
        assign t_im[gi]   = fit_tw(p_im);
        assign tw_ovf[gi] = ovf_tw(p_re) | ovf_tw(p_im);
      end else begin : g_pass
        assign t_re[gi]   = h_re_reg[gi+4];
        assign t_im[gi]   = h_im_reg[gi+4];
        assign tw_ovf[gi] = 1'b0;
      end
    end

    // Stage 3: X[k] = h[k] + t[k], X[k+4] = h[k] - t[k].
    for (gi = 0; gi < 4; gi++) begin : g_s3
      fft_bfly2 #(.DATA_W(DATA_W)) u_bfly (
        .rot_mj (gi == 2),
        .scale  (s2_scale_reg),
        .a_re   (h_re_reg[gi]),
        .a_im   (h_im_reg[gi]),
        .b_re   (t_re[gi]),
        .b_im   (t_im[gi]),
        .sum_re (o_re_next[gi]),
        .sum_im (o_im_next[gi]),
        .dif_re (o_re_next[gi+4]),
        .dif_im (o_im_next[gi+4])
`ifdef FFT8_SAT_EN
        ,
        .sat    (s3_ovf[gi])
`endif
      );
    end
  endgenerate

`ifdef FFT8_SAT_EN
  localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     PMAX = PW'(DMAX);
  localparam logic signed [PW-1:0]     PMIN = PW'(DMIN);

  function automatic logic signed [DATA_W-1:0] fit_tw(input logic signed [PW-1:0] v);
    if (v > PMAX) return DMAX;
    if (v < PMIN) return DMIN;
    return DATA_W'(v);
  endfunction

  function automatic logic ovf_tw(input logic signed [PW-1:0] v);
    return (v > PMAX) || (v < PMIN);
  endfunction

  // Sticky clamp indicator; only real (valid, advancing) frames count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (adv && ((accept && |s1_ovf) ||
                         (vld_reg[0] && |s2_ovf) ||
                         (vld_reg[1] && (|s3_ovf || |tw_ovf)))) begin
      sat_flag <= 1'b1;
    end
  end
`else
  function automatic logic signed [DATA_W-1:0] fit_tw(input logic signed [PW-1:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic ovf_tw(input logic signed [PW-1:0] v);
    return 1'b0 & v[0];
  endfunction

  assign s1_ovf = 4'b0;
  assign s2_ovf = 4'b0;
  assign s3_ovf = 4'b0;

  // Clamp detection is not built in the wrapping variant.
  logic unused_ovf;
  assign unused_ovf = ^{s1_ovf, s2_ovf, s3_ovf, tw_ovf};
`endif

  // ---------------------------------------------------------------- pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg      <= '0;
      s1_scale_reg <= 1'b0;
      s2_scale_reg <= 1'b0;
      for (int i = 0; i < NUM_PTS; i++) begin
        g_re_reg[i] <= '0;
        g_im_reg[i] <= '0;
        h_re_reg[i] <= '0;
        h_im_reg[i] <= '0;
        o_re_reg[i] <= '0;
        o_im_reg[i] <= '0;
      end
    end else if (adv) begin
      vld_reg      <= {vld_reg[NUM_STAGES-2:0], accept};
      s1_scale_reg <= scale_en;
      s2_scale_reg <= s1_scale_reg;
      g_re_reg     <= g_re_next;
      g_im_reg     <= g_im_next;
      h_re_reg     <= h_re_next;
      h_im_reg     <= h_im_next;
      o_re_reg     <= o_re_next;
      o_im_reg     <= o_im_next;
    end
  end

endmodule

// File: tb/tb_fft8_stream.sv
// tb_fft8_stream -- directed self-checking bench for fft8_stream.
// Build option: FFT8_SAT_EN (must match the RTL build).
module tb_fft8_stream;
  import fft8_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, scale_en, out_valid, out_ready;
  logic [8*W-1:0] in_re, in_im, out_re, out_im;
`ifdef FFT8_SAT_EN
  logic           sat_flag;
`endif

  int n_vec = 0;
  int n_err = 0;
  int fr_re [8], fr_im [8], exp_re [8], exp_im [8];

  always #5 clk = ~clk;

  fft8_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .scale_en  (scale_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
`ifdef FFT8_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  function automatic logic signed [W-1:0] bin_re(input int k);
    return out_re[k*W +: W];
  endfunction

  function automatic logic signed [W-1:0] bin_im(input int k);
    return out_im[k*W +: W];
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = 0; fr_im[i] = 0; exp_re[i] = 0; exp_im[i] = 0;
    end
  endtask

  task automatic apply_frame(input logic sc);
    for (int i = 0; i < 8; i++) begin
      in_re[i*W +: W] = 16'(fr_re[i]);
      in_im[i*W +: W] = 16'(fr_im[i]);
    end
    scale_en = sc;
    in_valid = 1'b1;
  endtask

  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Send one frame (pipe empty, out_ready high) and wait for its spectrum.
  task automatic run_frame(input logic sc, output bit got);
    apply_frame(sc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(got);
  endtask

  task automatic show(input string tag);
    $display("%s: X0=(%0d,%0d) X1=(%0d,%0d) X2=(%0d,%0d) X3=(%0d,%0d) X4=(%0d,%0d) X5=(%0d,%0d) X6=(%0d,%0d) X7=(%0d,%0d)",
             tag, bin_re(0), bin_im(0), bin_re(1), bin_im(1), bin_re(2), bin_im(2), bin_re(3), bin_im(3),
             bin_re(4), bin_im(4), bin_re(5), bin_im(5), bin_re(6), bin_im(6), bin_re(7), bin_im(7));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; scale_en = 1'b0;
    in_re = '0; in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_in_rst: got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if (out_re !== '0 || out_im !== '0) begin n_err++; $display("FAIL reset_out_data: got %h/%h want 0", out_re, out_im); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef FFT8_SAT_EN
    n_vec++;
    if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
`endif
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_impulse();
    clear_all();
    fr_re[0] = 100;
    for (int k = 0; k < 8; k++) exp_re[k] = 100;
    apply_frame(1'b0);
    @(posedge clk); #1;          // acceptance edge
    in_valid = 1'b0;
    for (int s = 1; s < NUM_STAGES; s++) begin
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL impulse_early_valid[%0d]: got %b want 0", s, out_valid); end
      @(posedge clk); #1;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL impulse_latency: out_valid got %b want 1", out_valid); end
    show("impulse");
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (bin_re(k) !== 16'(exp_re[k]) || bin_im(k) !== 16'(exp_im[k])) begin
        n_err++;
        $display("FAIL impulse X%0d: got (%0d,%0d) want (%0d,%0d)", k, bin_re(k), bin_im(k), exp_re[k], exp_im[k]);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL impulse_pulse_width: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_dc();
    bit got;
    for (int sc = 0; sc < 2; sc++) begin
      clear_all();
      for (int i = 0; i < 8; i++) fr_re[i] = 100;
      exp_re[0] = (sc == 1) ? 100 : 800;
      run_frame(sc[0], got);
      n_vec++;
      if (!got) begin
        n_err++; $display("FAIL dc_timeout(scale=%0d): out_valid got 0 want 1", sc);
      end else begin
        show((sc == 1) ? "dc_scaled" : "dc");
        for (int k = 0; k < 8; k++) begin
          n_vec++;
          if (bin_re(k) !== 16'(exp_re[k]) || bin_im(k) !== 16'(exp_im[k])) begin
            n_err++;
            $display("FAIL dc(scale=%0d) X%0d: got (%0d,%0d) want (%0d,%0d)", sc, k, bin_re(k), bin_im(k), exp_re[k], exp_im[k]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // x1 = 256 and x1 = 1 (the latter exercises floor rounding of the twiddle)
  task automatic test_twiddle();
    bit got;
    int a, c;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 256 : 1;
      c = (t == 0) ? 181 : 0;     // floor(a * 181 / 256)
      clear_all();
      fr_re[1] = a;
      exp_re[0] = a;   exp_im[0] = 0;
      exp_re[1] = c;   exp_im[1] = (t == 0) ? -181 : -1;
      exp_re[2] = 0;   exp_im[2] = -a;
      exp_re[3] = (t == 0) ? -181 : -1; exp_im[3] = (t == 0) ? -181 : -1;
      exp_re[4] = -a;  exp_im[4] = 0;
      exp_re[5] = -c;  exp_im[5] = (t == 0) ? 181 : 1;
      exp_re[6] = 0;   exp_im[6] = a;
      exp_re[7] = (t == 0) ? 181 : 1;   exp_im[7] = (t == 0) ? 181 : 1;
      run_frame(1'b0, got);
      n_vec++;
      if (!got) begin
        n_err++; $display("FAIL twiddle_timeout(x1=%0d): out_valid got 0 want 1", a);
      end else begin
        show((t == 0) ? "twiddle_x1_256" : "twiddle_x1_1");
        for (int k = 0; k < 8; k++) begin
          n_vec++;
          if (bin_re(k) !== 16'(exp_re[k]) || bin_im(k) !== 16'(exp_im[k])) begin
            n_err++;
            $display("FAIL twiddle(x1=%0d) X%0d: got (%0d,%0d) want (%0d,%0d)", a, k, bin_re(k), bin_im(k), exp_re[k], exp_im[k]);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // x2 = 100, x4 = 50j: exercises the exact -j paths and imaginary inputs.
  task automatic test_mixed();
    bit got;
    clear_all();
    fr_re[2] = 100; fr_im[4] = 50;
    exp_re[0] = 100;  exp_im[0] = 50;
    exp_re[1] = 0;    exp_im[1] = -150;
    exp_re[2] = -100; exp_im[2] = 50;
    exp_re[3] = 0;    exp_im[3] = 50;
    exp_re[4] = 100;  exp_im[4] = 50;
    exp_re[5] = 0;    exp_im[5] = -150;
    exp_re[6] = -100; exp_im[6] = 50;
    exp_re[7] = 0;    exp_im[7] = 50;
    run_frame(1'b0, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL mixed_timeout: out_valid got 0 want 1");
    end else begin
      show("mixed");
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (bin_re(k) !== 16'(exp_re[k]) || bin_im(k) !== 16'(exp_im[k])) begin
          n_err++;
          $display("FAIL mixed X%0d: got (%0d,%0d) want (%0d,%0d)", k, bin_re(k), bin_im(k), exp_re[k], exp_im[k]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int exp_x0 [3];
    int exp_x1 [3];
    int idx;
    exp_x0[0] = 100; exp_x0[1] = 800; exp_x0[2] = 256;
    exp_x1[0] = 100; exp_x1[1] = 0;   exp_x1[2] = 181;
    out_ready = 1'b1;
    clear_all(); fr_re[0] = 100; apply_frame(1'b0);
    @(posedge clk); #1;
    clear_all(); for (int i = 0; i < 8; i++) fr_re[i] = 100; apply_frame(1'b0);
    @(posedge clk); #1;
    clear_all(); fr_re[1] = 256; apply_frame(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || bin_re(0) !== 16'(exp_x0[0])) begin
      n_err++; $display("FAIL b2b_first: valid=%b X0=%0d want valid=1 X0=%0d", out_valid, bin_re(0), exp_x0[0]);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bin_re(0) !== 16'(exp_x0[0]) || bin_re(1) !== 16'(exp_x1[0])) begin
        n_err++;
        $display("FAIL b2b_hold[%0d]: valid=%b in_ready=%b X0=%0d X1=%0d want 1 0 %0d %0d",
                 c, out_valid, in_ready, bin_re(0), bin_re(1), exp_x0[0], exp_x1[0]);
      end
      $display("b2b stall cycle %0d: X0=%0d in_ready=%b", c, bin_re(0), in_ready);
    end
    out_ready = 1'b1;
    #1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) begin
        n_vec++;
        if (idx >= 3) begin
          n_err++; $display("FAIL b2b_extra: frame %0d X0=%0d want no more frames", idx, bin_re(0));
        end else if (bin_re(0) !== 16'(exp_x0[idx]) || bin_re(1) !== 16'(exp_x1[idx])) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: X0=%0d X1=%0d want %0d %0d", idx, bin_re(0), bin_re(1), exp_x0[idx], exp_x1[idx]);
        end
        $display("b2b frame %0d: X0=%0d X1=%0d", idx, bin_re(0), bin_re(1));
        idx++;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (idx != 3) begin n_err++; $display("FAIL b2b_count: got %0d frames want 3", idx); end
  endtask

  task automatic test_reset_inflight();
    int seen;
    out_ready = 1'b0;
    clear_all(); fr_re[0] = 100;
    apply_frame(1'b0);
    repeat (3) begin @(posedge clk); #1; end   // three accepted, one at output
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #2;
    rst = 1'b1;
    in_valid = 1'b1;                            // offered together with rst
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_re !== '0) begin
      n_err++; $display("FAIL rst_async: valid=%b out_re=%h want 0 and 0", out_valid, out_re);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL rst_flush: %0d output cycles after reset want 0", seen); end
    $display("reset in flight: outputs after release=%0d", seen);
  endtask

  task automatic test_overflow();
    bit got;
    clear_all();
    for (int i = 0; i < 8; i++) fr_re[i] = 32767;
`ifdef FFT8_SAT_EN
    exp_re[0] = 32767;
`else
    exp_re[0] = -8;     // 0xFFF8 after wrap at every stage
`endif
    run_frame(1'b0, got);
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL overflow_timeout: out_valid got 0 want 1");
    end else begin
      show("overflow");
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (bin_re(k) !== 16'(exp_re[k]) || bin_im(k) !== 16'(exp_im[k])) begin
          n_err++;
          $display("FAIL overflow X%0d: got (%0d,%0d) want (%0d,%0d)", k, bin_re(k), bin_im(k), exp_re[k], exp_im[k]);
        end
      end
`ifdef FFT8_SAT_EN
      n_vec++;
      if (sat_flag !== 1'b1) begin n_err++; $display("FAIL overflow_sat_flag: got %b want 1", sat_flag); end
`endif
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_twiddle();
    test_mixed();
    test_back_to_back();
    test_overflow();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
